// File: rtl/sata_define.sv
// Shared SATA link-layer constants: K28.5 comma, ALIGN primitive and PHY alignment FSM states.
package sata_define;

  localparam logic [7:0]  K28_5   = 8'hBC;
  localparam logic [31:0] P_ALIGN = 32'h7B4A4ABC;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'b00,
    ST_CHECK = 2'b01,
    ST_SYNC  = 2'b10
  } phy_state_e;

  // A lane carries a comma only when it is a clean K28.5.
  function automatic logic [3:0] comma_lanes(input logic [31:0] data,
                                             input logic [3:0]  k,
                                             input logic [3:0]  err);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[i] = k[i] && !err[i] && (data[8*i +: 8] == K28_5);
    end
    return m;
  endfunction

  function automatic logic [1:0] lowest_lane(input logic [3:0] m);
    logic [1:0] lane;
    if (m[0])      lane = 2'd0;
    else if (m[1]) lane = 2'd1;
    else if (m[2]) lane = 2'd2;
    else           lane = 2'd3;
    return lane;
  endfunction

endpackage

// File: rtl/rx_byte_rotate.sv
// Lane-rotation mux: builds the aligned dword (and its K/codeerr flags) from the
// registered previous word and the current word, starting at lane rot of the previous word.
module rx_byte_rotate (
  input  logic [31:0] cur_data,
  input  logic [3:0]  cur_k,
  input  logic [3:0]  cur_err,
  input  logic [31:0] prev_data,
  input  logic [3:0]  prev_k,
  input  logic [3:0]  prev_err,
  input  logic [1:0]  rot,
  output logic [31:0] rot_data,
  output logic [3:0]  rot_k,
  output logic [3:0]  rot_err
);

  always_comb begin
    rot_data = prev_data;
    rot_k    = prev_k;
    rot_err  = prev_err;
    case (rot)
      2'd1: begin
        rot_data = {cur_data[7:0], prev_data[31:8]};
        rot_k    = {cur_k[0], prev_k[3:1]};
        rot_err  = {cur_err[0], prev_err[3:1]};
      end
      2'd2: begin
        rot_data = {cur_data[15:0], prev_data[31:16]};
        rot_k    = {cur_k[1:0], prev_k[3:2]};
        rot_err  = {cur_err[1:0], prev_err[3:2]};
      end
      2'd3: begin
        rot_data = {cur_data[23:0], prev_data[31:24]};
        rot_k    = {cur_k[2:0], prev_k[3]};
        rot_err  = {cur_err[2:0], prev_err[3]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rx_phy_align.sv
// SATA RX byte aligner: hunts for K28.5, qualifies ALIGN primitives, tracks sync loss.
// Optional statistics counters are built only when SATA_RX_ALIGN_STATS_EN is defined.
module rx_phy_align
  import sata_define::*;
#(
  parameter int C_ALIGN_CNT = 3,
  parameter int C_LOSS_CNT  = 4
) (
  input  logic        clk_75m,
  input  logic        host_rst_n,
  input  logic [31:0] gtx_rxdata,
  input  logic [3:0]  gtx_rxdatak,
  input  logic [3:0]  gtx_rxcodeerr,
  output logic [31:0] phy2cs_data,
  output logic        phy2cs_k,
  output logic        phy_sync,
  output logic [1:0]  phy_rot,
  output logic [15:0] code_err_cnt,
  output logic [7:0]  sync_loss_cnt
);

  localparam logic [7:0] ALIGN_TGT = 8'(C_ALIGN_CNT);
  localparam logic [7:0] LOSS_TGT  = 8'(C_LOSS_CNT);

  phy_state_e  state_q, state_d;
  logic [1:0]  rot_q, rot_d;
  logic [31:0] d1_data_q, d1_data_d;
  logic [3:0]  d1_k_q, d1_k_d;
  logic [3:0]  d1_err_q, d1_err_d;
  logic [7:0]  align_cnt_q, align_cnt_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_k_q, out_k_d;
  logic        sync_q, sync_d;

  logic [31:0] al_data;
  logic [3:0]  al_k, al_err;
  logic [3:0]  raw_commas, al_commas;
  logic        al_is_align, al_bad_check, al_bad_sync;

  rx_byte_rotate u_rotate (
    .cur_data  (gtx_rxdata),
    .cur_k     (gtx_rxdatak),
    .cur_err   (gtx_rxcodeerr),
    .prev_data (d1_data_q),
    .prev_k    (d1_k_q),
    .prev_err  (d1_err_q),
    .rot       (rot_q),
    .rot_data  (al_data),
    .rot_k     (al_k),
    .rot_err   (al_err)
  );

  // Aligned lane 0 corresponds to raw lane j, so any comma in aligned lanes 1-3 is misplaced.
  assign raw_commas   = comma_lanes(gtx_rxdata, gtx_rxdatak, gtx_rxcodeerr);
  assign al_commas    = comma_lanes(al_data, al_k, al_err);
  assign al_is_align  = (al_data == P_ALIGN) && al_k[0];
  assign al_bad_check = (|al_err) || (|(al_commas & 4'b1110));
  assign al_bad_sync  = (|al_err) || (|al_k[3:1]);

  always_comb begin
    state_d     = state_q;
    rot_d       = rot_q;
    align_cnt_d = align_cnt_q;
    loss_cnt_d  = '0;
    d1_data_d   = gtx_rxdata;
    d1_k_d      = gtx_rxdatak;
    d1_err_d    = gtx_rxcodeerr;
    case (state_q)
      ST_HUNT: begin
        if (|raw_commas) begin
          rot_d       = lowest_lane(raw_commas);
          align_cnt_d = '0;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (al_bad_check) begin
          state_d = ST_HUNT;
        end else if (al_is_align) begin
          align_cnt_d = align_cnt_q + 8'd1;
          if (align_cnt_q + 8'd1 == ALIGN_TGT) state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (al_bad_sync) begin
          if (loss_cnt_q + 8'd1 == LOSS_TGT) begin
            state_d = ST_HUNT;
          end else begin
            loss_cnt_d = loss_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Data passes only while staying in SYNC, so the exit cycle already shows zeros.
    sync_d     = (state_d == ST_SYNC);
    out_data_d = '0;
    out_k_d    = 1'b0;
    if ((state_q == ST_SYNC) && (state_d == ST_SYNC)) begin
      out_data_d = al_data;
      out_k_d    = al_k[0];
    end
  end

  always_ff @(posedge clk_75m or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state_q     <= ST_HUNT;
      rot_q       <= '0;
      d1_data_q   <= '0;
      d1_k_q      <= '0;
      d1_err_q    <= '0;
      align_cnt_q <= '0;
      loss_cnt_q  <= '0;
      out_data_q  <= '0;
      out_k_q     <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rot_q       <= rot_d;
      d1_data_q   <= d1_data_d;
      d1_k_q      <= d1_k_d;
      d1_err_q    <= d1_err_d;
      align_cnt_q <= align_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      sync_q      <= sync_d;
    end
  end

  assign phy2cs_data = out_data_q;
  assign phy2cs_k    = out_k_q;
  assign phy_sync    = sync_q;
  assign phy_rot     = rot_q;

`ifdef SATA_RX_ALIGN_STATS_EN
  logic [15:0] code_err_cnt_q, code_err_cnt_d;
  logic [7:0]  sync_loss_cnt_q, sync_loss_cnt_d;
  logic        loss_evt;

  assign loss_evt = (state_q == ST_SYNC) && (state_d == ST_HUNT);

  always_comb begin
    code_err_cnt_d  = code_err_cnt_q;
    sync_loss_cnt_d = sync_loss_cnt_q;
    if ((|gtx_rxcodeerr) && (code_err_cnt_q != '1)) code_err_cnt_d = code_err_cnt_q + 16'd1;
    if (loss_evt && (sync_loss_cnt_q != '1)) sync_loss_cnt_d = sync_loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_75m or negedge host_rst_n) begin
    if (!host_rst_n) begin
      code_err_cnt_q  <= '0;
      sync_loss_cnt_q <= '0;
    end else begin
      code_err_cnt_q  <= code_err_cnt_d;
      sync_loss_cnt_q <= sync_loss_cnt_d;
    end
  end

  assign code_err_cnt  = code_err_cnt_q;
  assign sync_loss_cnt = sync_loss_cnt_q;
`else
  assign code_err_cnt  = '0;
  assign sync_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_phy_align.sv
// Bench for rx_phy_align: directed vector table, counter saturation run and random byte-stream
// traffic against a byte-window model. Build with and without SATA_RX_ALIGN_STATS_EN.
module tb_rx_phy_align;

  localparam int ALIGN_CNT = 3;
  localparam int LOSS_CNT  = 4;
  localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
`ifdef SATA_RX_ALIGN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int M_HUNT  = 0;
  localparam int M_CHECK = 1;
  localparam int M_SYNC  = 2;

  logic        clk_75m = 1'b0;
  logic        host_rst_n;
  logic [31:0] gtx_rxdata;
  logic [3:0]  gtx_rxdatak;
  logic [3:0]  gtx_rxcodeerr;
  logic [31:0] phy2cs_data;
  logic        phy2cs_k;
  logic        phy_sync;
  logic [1:0]  phy_rot;
  logic [15:0] code_err_cnt;
  logic [7:0]  sync_loss_cnt;

  int checksTotal  = 0;
  int checksPassed = 0;

  always #5 clk_75m = ~clk_75m;

  rx_phy_align #(.C_ALIGN_CNT(ALIGN_CNT), .C_LOSS_CNT(LOSS_CNT)) dut (
    .clk_75m       (clk_75m),
    .host_rst_n    (host_rst_n),
    .gtx_rxdata    (gtx_rxdata),
    .gtx_rxdatak   (gtx_rxdatak),
    .gtx_rxcodeerr (gtx_rxcodeerr),
    .phy2cs_data   (phy2cs_data),
    .phy2cs_k      (phy2cs_k),
    .phy_sync      (phy_sync),
    .phy_rot       (phy_rot),
    .code_err_cnt  (code_err_cnt),
    .sync_loss_cnt (sync_loss_cnt)
  );

  // Reference model: an 8-byte window (previous word then current word), read from offset rot.
  byte unsigned prevB[4];
  bit          prevK[4];
  bit          prevE[4];
  int          mMode, mRot, mRun, mMiss, mErrCnt, mLossCnt;
  logic [31:0] eData;
  bit          eK;

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      prevB[i] = 8'h00; prevK[i] = 1'b0; prevE[i] = 1'b0;
    end
    mMode = M_HUNT; mRot = 0; mRun = 0; mMiss = 0; mErrCnt = 0; mLossCnt = 0;
    eData = '0; eK = 1'b0;
  endfunction

  function automatic void modelStep(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    byte unsigned win[8];
    bit wk[8], we[8];
    byte unsigned a[4];
    bit ak[4], ae[4];
    bit anyErr, misplaced, extraK;
    int oldMode, first;
    logic [31:0] aw;
    for (int i = 0; i < 4; i++) begin
      win[i] = prevB[i]; wk[i] = prevK[i]; we[i] = prevE[i];
      win[i+4] = d[8*i +: 8]; wk[i+4] = k[i]; we[i+4] = e[i];
    end
    anyErr = 0; misplaced = 0; extraK = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = win[mRot+i]; ak[i] = wk[mRot+i]; ae[i] = we[mRot+i];
      aw[8*i +: 8] = a[i];
      if (ae[i]) anyErr = 1;
      if (i > 0 && ak[i]) extraK = 1;
      if (i > 0 && ak[i] && !ae[i] && a[i] == 8'hBC) misplaced = 1;
    end
    oldMode = mMode;
    if (mMode == M_HUNT) begin
      first = -1;
      for (int i = 3; i >= 0; i--)
        if (k[i] && !e[i] && d[8*i +: 8] == 8'hBC) first = i;
      if (first >= 0) begin
        mRot = first; mRun = 0; mMode = M_CHECK;
      end
    end else if (mMode == M_CHECK) begin
      if (anyErr || misplaced) mMode = M_HUNT;
      else if (ak[0] && aw == ALIGN_W) begin
        mRun++;
        if (mRun == ALIGN_CNT) mMode = M_SYNC;
      end
    end else begin
      if (anyErr || extraK) begin
        mMiss++;
        if (mMiss == LOSS_CNT) begin
          mMode = M_HUNT; mMiss = 0;
          if (mLossCnt < 255) mLossCnt++;
        end
      end else mMiss = 0;
    end
    if (oldMode == M_SYNC && mMode == M_SYNC) begin
      eData = aw; eK = ak[0];
    end else begin
      eData = '0; eK = 1'b0;
    end
    if (e != 4'b0000 && mErrCnt < 65535) mErrCnt++;
    for (int i = 0; i < 4; i++) begin
      prevB[i] = win[i+4]; prevK[i] = wk[i+4]; prevE[i] = we[i+4];
    end
  endfunction

  // Drive one word, let it be clocked in, and advance the model alongside.
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e);
    gtx_rxdata = d; gtx_rxdatak = k; gtx_rxcodeerr = e;
    @(posedge clk_75m);
    modelStep(d, k, e);
    #1;
  endtask

  task automatic checkOutput(input string name);
    logic [15:0] expErr;
    logic [7:0]  expLoss;
    expErr  = STATS ? 16'(mErrCnt) : 16'd0;
    expLoss = STATS ? 8'(mLossCnt) : 8'd0;
    checksTotal++;
    if (phy2cs_data === eData && phy2cs_k === eK && phy_sync === (mMode == M_SYNC) &&
        phy_rot === 2'(mRot) && code_err_cnt === expErr && sync_loss_cnt === expLoss)
      checksPassed++;
    else
      $display("[TB] FAIL %s: got data=%h k=%b sync=%b rot=%0d errcnt=%0d losscnt=%0d, want data=%h k=%b sync=%b rot=%0d errcnt=%0d losscnt=%0d",
               name, phy2cs_data, phy2cs_k, phy_sync, phy_rot, code_err_cnt, sync_loss_cnt,
               eData, eK, (mMode == M_SYNC), mRot, expErr, expLoss);
  endtask

  task automatic checkZero(input string name);
    checksTotal++;
    if (phy2cs_data === '0 && phy2cs_k === 1'b0 && phy_sync === 1'b0 && phy_rot === 2'd0 &&
        code_err_cnt === '0 && sync_loss_cnt === '0)
      checksPassed++;
    else
      $display("[TB] FAIL %s: got data=%h k=%b sync=%b rot=%0d errcnt=%0d losscnt=%0d, want all zero",
               name, phy2cs_data, phy2cs_k, phy_sync, phy_rot, code_err_cnt, sync_loss_cnt);
  endtask

  // Reset asserted between clock edges must clear the outputs without waiting for a clock.
  task automatic doMidReset();
    #3;
    host_rst_n = 1'b0;
    #1;
    checkZero("async reset");
    modelReset();
    @(posedge clk_75m);
    #3;
    host_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  err;
    bit          rst;
    logic [31:0] expData;
    bit          expK;
    bit          expSync;
    logic [1:0]  expRot;
    bit          chkStats;
    int          statErr;
    int          statLoss;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [31:0] d, input logic [3:0] k, input logic [3:0] e,
                                 input bit r, input logic [31:0] ed, input bit ek, input bit es,
                                 input logic [1:0] er);
    vec_t v;
    v.data = d; v.k = k; v.err = e; v.rst = r;
    v.expData = ed; v.expK = ek; v.expSync = es; v.expRot = er;
    v.chkStats = 0; v.statErr = 0; v.statLoss = 0;
    vecs.push_back(v);
  endfunction

  task automatic runTable();
    logic [31:0] w, x, y, z;
    w = 32'h4ABC7B4A;
    x = 32'h4A4ABC7B;
    y = 32'hBC4A4A7B;
    z = 32'h11223344;
    // Lane 0 aligned: sync after the third qualifying ALIGN, data two clocks behind input.
    addVec(ALIGN_W, 4'b0001, 4'h0, 1, '0, 0, 0, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, '0, 0, 0, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, '0, 0, 0, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, '0, 0, 1, 2'd0);
    addVec(32'hB5B5957C, 4'b0001, 4'h0, 0, ALIGN_W, 1, 1, 2'd0);
    addVec(32'h00000000, 4'b0000, 4'h0, 0, 32'hB5B5957C, 1, 1, 2'd0);
    addVec(32'h12345678, 4'b0000, 4'h0, 0, 32'h00000000, 0, 1, 2'd0);
    // Reset mid-SYNC, then full reacquisition.
    addVec(ALIGN_W, 4'b0001, 4'h0, 1, '0, 0, 0, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, '0, 0, 0, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, '0, 0, 0, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, '0, 0, 1, 2'd0);
    addVec(ALIGN_W, 4'b0001, 4'h0, 0, ALIGN_W, 1, 1, 2'd0);
    // Comma in lane 2.
    addVec(w, 4'b0100, 4'h0, 1, '0, 0, 0, 2'd2);
    addVec(w, 4'b0100, 4'h0, 0, '0, 0, 0, 2'd2);
    addVec(w, 4'b0100, 4'h0, 0, '0, 0, 0, 2'd2);
    addVec(w, 4'b0100, 4'h0, 0, '0, 0, 1, 2'd2);
    addVec(w, 4'b0100, 4'h0, 0, ALIGN_W, 1, 1, 2'd2);
    // Three errors, a good word, three errors: sync holds.
    for (int i = 0; i < 3; i++) addVec(w, 4'b0100, 4'h1, 0, ALIGN_W, 1, 1, 2'd2);
    addVec(w, 4'b0100, 4'h0, 0, ALIGN_W, 1, 1, 2'd2);
    for (int i = 0; i < 3; i++) addVec(w, 4'b0100, 4'h1, 0, ALIGN_W, 1, 1, 2'd2);
    addVec(w, 4'b0100, 4'h0, 0, ALIGN_W, 1, 1, 2'd2);
    // Four consecutive errors: loss of sync on the fourth.
    for (int i = 0; i < 3; i++) addVec(w, 4'b0100, 4'h1, 0, ALIGN_W, 1, 1, 2'd2);
    addVec(w, 4'b0100, 4'h1, 0, '0, 0, 0, 2'd2);
    vecs[vecs.size()-1].chkStats = 1;
    vecs[vecs.size()-1].statErr  = 10;
    vecs[vecs.size()-1].statLoss = 1;
    addVec(w, 4'b0100, 4'h0, 0, '0, 0, 0, 2'd2);
    // CHECK with j=1, stray comma in raw lane 3 drops to HUNT, then j relatches to 3.
    addVec(x, 4'b0010, 4'h0, 1, '0, 0, 0, 2'd1);
    addVec(x, 4'b0010, 4'h0, 0, '0, 0, 0, 2'd1);
    addVec(y, 4'b1000, 4'h0, 0, '0, 0, 0, 2'd1);
    addVec(z, 4'b0000, 4'h0, 0, '0, 0, 0, 2'd1);
    addVec(y, 4'b1000, 4'h0, 0, '0, 0, 0, 2'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doMidReset();
      applyStimulus(vecs[i].data, vecs[i].k, vecs[i].err);
      checkOutput($sformatf("vec%0d model", i));
      checksTotal++;
      if (phy2cs_data === vecs[i].expData && phy2cs_k === vecs[i].expK &&
          phy_sync === vecs[i].expSync && phy_rot === vecs[i].expRot)
        checksPassed++;
      else
        $display("[TB] FAIL vec%0d: got data=%h k=%b sync=%b rot=%0d, want data=%h k=%b sync=%b rot=%0d",
                 i, phy2cs_data, phy2cs_k, phy_sync, phy_rot,
                 vecs[i].expData, vecs[i].expK, vecs[i].expSync, vecs[i].expRot);
      if (vecs[i].chkStats) begin
        checksTotal++;
        if (code_err_cnt === (STATS ? 16'(vecs[i].statErr) : 16'd0) &&
            sync_loss_cnt === (STATS ? 8'(vecs[i].statLoss) : 8'd0))
          checksPassed++;
        else
          $display("[TB] FAIL vec%0d stats: got errcnt=%0d losscnt=%0d, want errcnt=%0d losscnt=%0d",
                   i, code_err_cnt, sync_loss_cnt, STATS ? vecs[i].statErr : 0,
                   STATS ? vecs[i].statLoss : 0);
      end
    end
  endtask

  // Repeated acquire/lose cycles push the loss counter past its saturation point.
  task automatic runSaturation();
    doMidReset();
    for (int n = 0; n < 258; n++) begin
      for (int i = 0; i < 4; i++) applyStimulus(ALIGN_W, 4'b0001, 4'h0);
      for (int i = 0; i < 5; i++) applyStimulus(ALIGN_W, 4'b0001, 4'h1);
      checkOutput("saturation loop");
    end
    checksTotal++;
    if (sync_loss_cnt === (STATS ? 8'd255 : 8'd0) && code_err_cnt === (STATS ? 16'd1290 : 16'd0))
      checksPassed++;
    else
      $display("[TB] FAIL saturation: got losscnt=%0d errcnt=%0d, want losscnt=%0d errcnt=%0d",
               sync_loss_cnt, code_err_cnt, STATS ? 255 : 0, STATS ? 1290 : 0);
  endtask

  // Random byte stream of ALIGNs, data and other primitives, realigned by random filler bytes.
  task automatic runRandom();
    byte unsigned bq[$];
    bit kq[$];
    int fill, len, errMode, r;
    logic [31:0] d;
    logic [3:0] k, e;
    doMidReset();
    for (int s = 0; s < 24; s++) begin
      fill    = $urandom_range(0, 3);
      len     = $urandom_range(4, 16);
      errMode = $urandom_range(0, 3);
      for (int f = 0; f < fill; f++) begin
        bq.push_back(8'($urandom_range(0, 255))); kq.push_back(1'b0);
      end
      for (int w = 0; w < len; w++) begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          bq.push_back(8'hBC); bq.push_back(8'h4A); bq.push_back(8'h4A); bq.push_back(8'h7B);
          kq.push_back(1'b1);
        end else if (r < 9) begin
          for (int b = 0; b < 4; b++) bq.push_back(8'($urandom_range(0, 255)));
          kq.push_back(1'b0);
        end else begin
          bq.push_back(8'h7C); bq.push_back(8'h95); bq.push_back(8'hB5); bq.push_back(8'hB5);
          kq.push_back(1'b1);
        end
        for (int b = 0; b < 3; b++) kq.push_back(1'b0);
      end
      while (bq.size() >= 4) begin
        for (int i = 0; i < 4; i++) begin
          d[8*i +: 8] = bq.pop_front();
          k[i] = kq.pop_front();
        end
        e = 4'h0;
        if (errMode == 2 && $urandom_range(0, 9) == 0) e = 4'($urandom_range(1, 15));
        if (errMode == 3 && $urandom_range(0, 1) == 0) e = 4'($urandom_range(1, 15));
        applyStimulus(d, k, e);
        checkOutput("random");
      end
    end
  endtask

  initial begin
    host_rst_n    = 1'b0;
    gtx_rxdata    = '0;
    gtx_rxdatak   = '0;
    gtx_rxcodeerr = '0;
    modelReset();
    repeat (2) @(posedge clk_75m);
    #1;
    checkZero("reset state");
    #3;
    host_rst_n = 1'b1;
    runTable();
    runSaturation();
    runRandom();
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
